// File: rtl/sdram_arbiter_if.sv
// Bundle of the VGA, CPU and SDRAM-controller signals around the arbiter.
// The master modport is the arbiter's view; slave is the surrounding ports and controller.
interface sdram_arbiter_if;
    logic        vga_request;
    logic [25:0] vga_address;
    logic        vga_ready;
    logic        vga_rvalid;
    logic [31:0] vga_rdata;
    logic        vga_complete;

    logic        cpu_request;
    logic [25:0] cpu_address;
    logic        cpu_write;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wmask;
    logic        cpu_ready;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_complete;

    logic        sdram_request;
    logic [25:0] sdram_address;
    logic        sdram_write;
    logic        sdram_burst;
    logic [31:0] sdram_wdata;
    logic [3:0]  sdram_wmask;
    logic        sdram_ready;
    logic        sdram_rvalid;
    logic [31:0] sdram_rdata;
    logic        sdram_complete;

    modport master (
        input  vga_request, vga_address,
        output vga_ready, vga_rvalid, vga_rdata, vga_complete,
        input  cpu_request, cpu_address, cpu_write, cpu_wdata, cpu_wmask,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_complete,
        output sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wdata, sdram_wmask,
        input  sdram_ready, sdram_rvalid, sdram_rdata, sdram_complete
    );

    modport slave (
        output vga_request, vga_address,
        input  vga_ready, vga_rvalid, vga_rdata, vga_complete,
        output cpu_request, cpu_address, cpu_write, cpu_wdata, cpu_wmask,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_complete,
        input  sdram_request, sdram_address, sdram_write, sdram_burst, sdram_wdata, sdram_wmask,
        output sdram_ready, sdram_rvalid, sdram_rdata, sdram_complete
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Two-port (VGA burst read / CPU single word) arbiter in front of an SDRAM controller.
// Define SDRAM_ARB_FAIR_EN for round-robin on contention; otherwise VGA has strict priority.
//
// Handshake: a port holds request/address until its ready pulses; sdram_request
// stays high until sdram_ready is sampled; sdram_complete ends ownership.
module sdram_arbiter (
    input  logic                  clock,
    input  logic                  reset,
    sdram_arbiter_if.master       bus,
    output logic [1:0]            state_dbg,
    output logic                  last_owner_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VGA_ACT = 2'd1,
        CPU_ACT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_owner_q, last_owner_d;   // 1 = CPU granted last
    logic        sdram_request_q, sdram_request_d;
    logic [25:0] sdram_address_q, sdram_address_d;
    logic        sdram_write_q, sdram_write_d;
    logic        sdram_burst_q, sdram_burst_d;
    logic [31:0] sdram_wdata_q, sdram_wdata_d;
    logic [3:0]  sdram_wmask_q, sdram_wmask_d;
    logic        grant_vga, grant_cpu;
    logic        vga_own, cpu_own;

    always_comb begin
        grant_vga = 1'b0;
        grant_cpu = 1'b0;
`ifdef SDRAM_ARB_FAIR_EN
        if (bus.vga_request && bus.cpu_request) begin
            grant_vga = last_owner_q;
            grant_cpu = !last_owner_q;
        end else begin
            grant_vga = bus.vga_request;
            grant_cpu = bus.cpu_request;
        end
`else
        grant_vga = bus.vga_request;
        grant_cpu = bus.cpu_request && !bus.vga_request;
`endif
    end

    always_comb begin
        state_d         = state_q;
        last_owner_d    = last_owner_q;
        sdram_request_d = sdram_request_q;
        sdram_address_d = sdram_address_q;
        sdram_write_d   = sdram_write_q;
        sdram_burst_d   = sdram_burst_q;
        sdram_wdata_d   = sdram_wdata_q;
        sdram_wmask_d   = sdram_wmask_q;
        case (state_q)
            IDLE: begin
                if (grant_vga) begin
                    state_d         = VGA_ACT;
                    last_owner_d    = 1'b0;
                    sdram_request_d = 1'b1;
                    sdram_address_d = bus.vga_address;
                    sdram_write_d   = 1'b0;
                    sdram_burst_d   = 1'b1;
                    sdram_wdata_d   = 32'd0;
                    sdram_wmask_d   = 4'd0;
                end else if (grant_cpu) begin
                    state_d         = CPU_ACT;
                    last_owner_d    = 1'b1;
                    sdram_request_d = 1'b1;
                    sdram_address_d = bus.cpu_address;
                    sdram_write_d   = bus.cpu_write;
                    sdram_burst_d   = 1'b0;
                    sdram_wdata_d   = bus.cpu_wdata;
                    sdram_wmask_d   = bus.cpu_wmask;
                end
            end
            VGA_ACT, CPU_ACT: begin
                if (sdram_request_q && bus.sdram_ready) sdram_request_d = 1'b0;
                // Returning to IDLE first gives the 2-cycle gap before the next command.
                if (bus.sdram_complete) begin
                    state_d         = IDLE;
                    sdram_request_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= IDLE;
            last_owner_q    <= 1'b1;
            sdram_request_q <= 1'b0;
            sdram_address_q <= 26'd0;
            sdram_write_q   <= 1'b0;
            sdram_burst_q   <= 1'b0;
            sdram_wdata_q   <= 32'd0;
            sdram_wmask_q   <= 4'd0;
        end else begin
            state_q         <= state_d;
            last_owner_q    <= last_owner_d;
            sdram_request_q <= sdram_request_d;
            sdram_address_q <= sdram_address_d;
            sdram_write_q   <= sdram_write_d;
            sdram_burst_q   <= sdram_burst_d;
            sdram_wdata_q   <= sdram_wdata_d;
            sdram_wmask_q   <= sdram_wmask_d;
        end
    end

    // Reset gating keeps port strobes quiet on the reset cycle itself.
    assign vga_own = !reset && (state_q == VGA_ACT);
    assign cpu_own = !reset && (state_q == CPU_ACT);

    assign bus.vga_ready    = vga_own && bus.sdram_ready;
    assign bus.vga_rvalid   = vga_own && bus.sdram_rvalid;
    assign bus.vga_complete = vga_own && bus.sdram_complete;
    assign bus.vga_rdata    = bus.sdram_rdata;
    assign bus.cpu_ready    = cpu_own && bus.sdram_ready;
    assign bus.cpu_rvalid   = cpu_own && bus.sdram_rvalid;
    assign bus.cpu_complete = cpu_own && bus.sdram_complete;
    assign bus.cpu_rdata    = bus.sdram_rdata;

    assign bus.sdram_request = sdram_request_q;
    assign bus.sdram_address = sdram_address_q;
    assign bus.sdram_write   = sdram_write_q;
    assign bus.sdram_burst   = sdram_burst_q;
    assign bus.sdram_wdata   = sdram_wdata_q;
    assign bus.sdram_wmask   = sdram_wmask_q;

    assign state_dbg      = state_q;
    assign last_owner_dbg = last_owner_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter; expectations follow SDRAM_ARB_FAIR_EN.
module tb_sdram_arbiter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] state_dbg;
    logic       last_owner_dbg;
    int         total = 0;
    int         bad = 0;
    int         seen;
    logic [1:0] exp_second;
    logic       exp_last;

    sdram_arbiter_if bus ();

    sdram_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .bus            (bus),
        .state_dbg      (state_dbg),
        .last_owner_dbg (last_owner_dbg)
    );

    always #4 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.vga_request    = 1'b0;
        bus.vga_address    = 26'd0;
        bus.cpu_request    = 1'b0;
        bus.cpu_address    = 26'd0;
        bus.cpu_write      = 1'b0;
        bus.cpu_wdata      = 32'd0;
        bus.cpu_wmask      = 4'd0;
        bus.sdram_ready    = 1'b0;
        bus.sdram_rvalid   = 1'b0;
        bus.sdram_rdata    = 32'd0;
        bus.sdram_complete = 1'b0;
    endtask

    initial begin
        clear_inputs();
`ifdef SDRAM_ARB_FAIR_EN
        exp_second = 2'd2;
        exp_last   = 1'b1;
`else
        exp_second = 2'd1;
        exp_last   = 1'b0;
`endif
        // Reset, with controller strobes driven to show port outputs stay 0
        cyc();
        bus.sdram_ready = 1'b1; bus.sdram_rvalid = 1'b1; bus.sdram_complete = 1'b1;
        #1;
        chk("rst_vga_rvalid", bus.vga_rvalid, 0);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        cyc();
        clear_inputs();
        reset = 1'b0;
        #1;
        chk("rst_state", state_dbg, 0);
        chk("rst_sdram_request", bus.sdram_request, 0);
        chk("rst_sdram_write", bus.sdram_write, 0);
        chk("rst_sdram_burst", bus.sdram_burst, 0);
        chk("rst_sdram_address", bus.sdram_address, 0);
        chk("rst_sdram_wdata", bus.sdram_wdata, 0);
        chk("rst_sdram_wmask", bus.sdram_wmask, 0);
        chk("rst_last_owner", last_owner_dbg, 1);

        // Stray controller responses in IDLE
        cyc();
        bus.sdram_rvalid = 1'b1; bus.sdram_rdata = 32'h12345678;
        bus.sdram_ready = 1'b1; bus.sdram_complete = 1'b1;
        #1;
        chk("stray_vga_rvalid", bus.vga_rvalid, 0);
        chk("stray_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("stray_vga_ready", bus.vga_ready, 0);
        chk("stray_cpu_complete", bus.cpu_complete, 0);
        cyc();
        clear_inputs();
        chk("stray_state", state_dbg, 0);
        chk("stray_sdram_request", bus.sdram_request, 0);

        // VGA 16-word burst read
        bus.vga_request = 1'b1; bus.vga_address = 26'h3F80000;
        #1;
        chk("vga_ready_idle", bus.vga_ready, 0);
        cyc();
        chk("vga_state", state_dbg, 1);
        chk("vga_sdram_request", bus.sdram_request, 1);
        chk("vga_burst", bus.sdram_burst, 1);
        chk("vga_write", bus.sdram_write, 0);
        chk("vga_address", bus.sdram_address, 26'h3F80000);
        chk("vga_wdata", bus.sdram_wdata, 0);
        chk("vga_wmask", bus.sdram_wmask, 0);
        bus.sdram_ready = 1'b1;
        #1;
        chk("vga_ready", bus.vga_ready, 1);
        chk("vga_cpu_ready", bus.cpu_ready, 0);
        cyc();
        chk("vga_request_cleared", bus.sdram_request, 0);
        chk("vga_address_held", bus.sdram_address, 26'h3F80000);
        bus.vga_request = 1'b0; bus.vga_address = 26'd0; bus.sdram_ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 16; i++) begin
            bus.sdram_rvalid = 1'b1; bus.sdram_rdata = 32'(i);
            #1;
            chk("vga_rvalid", bus.vga_rvalid, 1);
            chk("vga_rdata", bus.vga_rdata, 32'(i));
            if (bus.cpu_rvalid || bus.cpu_ready || bus.cpu_complete) seen++;
            cyc();
        end
        bus.sdram_rvalid = 1'b0; bus.sdram_complete = 1'b1;
        #1;
        chk("vga_complete", bus.vga_complete, 1);
        chk("vga_cpu_complete", bus.cpu_complete, 0);
        chk("vga_cpu_outputs_quiet", seen, 0);
        cyc();
        bus.sdram_complete = 1'b0;
        chk("vga_back_idle", state_dbg, 0);

        // CPU single-word write
        bus.cpu_request = 1'b1; bus.cpu_address = 26'h0000100; bus.cpu_write = 1'b1;
        bus.cpu_wdata = 32'hDEADBEEF; bus.cpu_wmask = 4'hF;
        cyc();
        chk("cpuw_state", state_dbg, 2);
        chk("cpuw_sdram_request", bus.sdram_request, 1);
        chk("cpuw_write", bus.sdram_write, 1);
        chk("cpuw_burst", bus.sdram_burst, 0);
        chk("cpuw_address", bus.sdram_address, 26'h0000100);
        chk("cpuw_wdata", bus.sdram_wdata, 32'hDEADBEEF);
        chk("cpuw_wmask", bus.sdram_wmask, 4'hF);
        bus.sdram_ready = 1'b1;
        #1;
        chk("cpuw_cpu_ready", bus.cpu_ready, 1);
        chk("cpuw_vga_ready", bus.vga_ready, 0);
        cyc();
        clear_inputs();
        chk("cpuw_wdata_held", bus.sdram_wdata, 32'hDEADBEEF);
        cyc();
        bus.sdram_complete = 1'b1;
        #1;
        chk("cpuw_complete", bus.cpu_complete, 1);
        chk("cpuw_rvalid", bus.cpu_rvalid, 0);
        cyc();
        bus.sdram_complete = 1'b0;
        chk("cpuw_back_idle", state_dbg, 0);

        // Contention twice back-to-back
        bus.vga_request = 1'b1; bus.vga_address = 26'h0001000;
        bus.cpu_request = 1'b1; bus.cpu_address = 26'h0000300;
        cyc();
        chk("both1_state", state_dbg, 1);
        bus.sdram_ready = 1'b1;
        #1;
        chk("both1_vga_ready", bus.vga_ready, 1);
        chk("both1_cpu_ready", bus.cpu_ready, 0);
        cyc();
        bus.sdram_ready = 1'b0; bus.vga_request = 1'b0;
        cyc();
        bus.sdram_complete = 1'b1; bus.vga_request = 1'b1;
        #1;
        chk("both1_complete", bus.vga_complete, 1);
        cyc();
        bus.sdram_complete = 1'b0;
        chk("both_gap_state", state_dbg, 0);
        chk("both_gap_request", bus.sdram_request, 0);
        cyc();
        chk("both2_state", state_dbg, exp_second);
        chk("both2_sdram_request", bus.sdram_request, 1);
        chk("both2_burst", bus.sdram_burst, (exp_second == 2'd1) ? 1 : 0);
        chk("both2_last_owner", last_owner_dbg, exp_last);
        clear_inputs();
        bus.sdram_ready = 1'b1;
        cyc();
        bus.sdram_ready = 1'b0; bus.sdram_complete = 1'b1;
        cyc();
        bus.sdram_complete = 1'b0;
        chk("both_end_state", state_dbg, 0);

        // CPU request arriving with VGA's sdram_complete
        bus.vga_request = 1'b1; bus.vga_address = 26'h0002000;
        cyc();
        chk("late_vga_state", state_dbg, 1);
        bus.sdram_ready = 1'b1;
        cyc();
        bus.sdram_ready = 1'b0; bus.vga_request = 1'b0;
        bus.sdram_complete = 1'b1;
        bus.cpu_request = 1'b1; bus.cpu_address = 26'h0000200; bus.cpu_write = 1'b0;
        #1;
        chk("late_cpu_ready_on_complete", bus.cpu_ready, 0);
        cyc();
        bus.sdram_complete = 1'b0;
        chk("late_gap_state", state_dbg, 0);
        chk("late_gap_request", bus.sdram_request, 0);
        cyc();
        chk("late_cpu_state", state_dbg, 2);
        chk("late_sdram_request", bus.sdram_request, 1);
        chk("late_write", bus.sdram_write, 0);
        chk("late_address", bus.sdram_address, 26'h0000200);
        bus.sdram_ready = 1'b1;
        #1;
        chk("late_cpu_ready", bus.cpu_ready, 1);
        cyc();
        clear_inputs();
        bus.sdram_rvalid = 1'b1; bus.sdram_rdata = 32'hCAFE0001;
        #1;
        chk("late_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("late_cpu_rdata", bus.cpu_rdata, 32'hCAFE0001);
        chk("late_vga_rvalid", bus.vga_rvalid, 0);
        cyc();
        bus.sdram_rvalid = 1'b0; bus.sdram_complete = 1'b1;
        cyc();
        bus.sdram_complete = 1'b0;
        chk("late_end_state", state_dbg, 0);

        // Reset in the middle of a VGA burst
        bus.vga_request = 1'b1; bus.vga_address = 26'h3F80000;
        cyc();
        chk("abort_state", state_dbg, 1);
        bus.sdram_ready = 1'b1;
        cyc();
        bus.sdram_ready = 1'b0; bus.vga_request = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sdram_rvalid = 1'b1; bus.sdram_rdata = 32'(i);
            cyc();
        end
        reset = 1'b1; bus.sdram_rdata = 32'd5;
        #1;
        chk("abort_rvalid_in_reset", bus.vga_rvalid, 0);
        cyc();
        reset = 1'b0;
        chk("abort_state_idle", state_dbg, 0);
        chk("abort_sdram_request", bus.sdram_request, 0);
        seen = 0;
        for (int i = 6; i < 16; i++) begin
            bus.sdram_rdata = 32'(i);
            #1;
            if (bus.vga_rvalid || bus.cpu_rvalid) seen++;
            cyc();
        end
        bus.sdram_rvalid = 1'b0; bus.sdram_complete = 1'b1;
        #1;
        chk("abort_vga_complete", bus.vga_complete, 0);
        chk("abort_rvalid_dropped", seen, 0);
        cyc();
        clear_inputs();
        chk("abort_final_state", state_dbg, 0);
        chk("abort_final_request", bus.sdram_request, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 clock  in  1  system clock, 125MHz; reset  in  1  reset, synchronous, active-high.
REQ-002 vga_request in 1, vga_address in 26, vga_ready out 1, vga_rvalid out 1, vga_rdata out 32, vga_complete out 1: display port, 16-word burst read only.
REQ-003 cpu_request in 1, cpu_address in 26, cpu_write in 1, cpu_wdata in 32, cpu_wmask in 4, cpu_ready out 1, cpu_rvalid out 1, cpu_rdata out 32, cpu_complete out 1: CPU port, single-word access.
REQ-004 sdram_request out 1, sdram_address out 26, sdram_write out 1, sdram_burst out 1 (1 = 16-word read), sdram_wdata out 32, sdram_wmask out 4: controller command side.
REQ-005 sdram_ready in 1, sdram_rvalid in 1, sdram_rdata in 32, sdram_complete in 1: controller response side.

Function
REQ-006 FSM states IDLE, VGA_ACT, CPU_ACT; owner = port of current ACT state.
REQ-007 IDLE with a grantable request: next cycle state = owner ACT, sdram_request=1, command fields registered from owner port (VGA: burst=1, write=0, wmask=0, wdata=0; CPU: burst=0, fields copied).
REQ-008 Command fields stay constant while in ACT state.
REQ-009 sdram_request clears the cycle after sdram_ready=1 is sampled; stays high until then.
REQ-010 Owner's ready/rvalid/complete equal the controller's same-cycle inputs (combinational); non-owner's are 0.
REQ-011 vga_rdata and cpu_rdata both equal sdram_rdata at all times; qualify with rvalid only.
REQ-012 sdram_complete in ACT: next state IDLE; earliest next sdram_request is 2 cycles after the complete cycle.
REQ-013 Request arriving with sdram_complete: not granted that cycle; arbitrated in IDLE next cycle.
REQ-014 sdram_rvalid/ready/complete in IDLE: ignored, not forwarded.
REQ-015 Ports hold request and address until their ready; arbiter does not latch requests ahead of grant.
REQ-016 CPU writes: controller returns sdram_complete, no rvalid; arbiter passes through unchanged.
REQ-017 No request in IDLE: stay IDLE, sdram_request=0.

Reset
REQ-018 Reset: state IDLE; sdram_request, sdram_write, sdram_burst = 0; sdram_address, sdram_wdata = 0; sdram_wmask = 0; last_owner = CPU.
REQ-019 Reset mid-transaction aborts ownership; later controller responses dropped per REQ-014.
REQ-020 All port outputs 0 during reset and in IDLE.

Configuration
REQ-021 Macro SDRAM_ARB_FAIR_EN.
REQ-022 Undefined: strict priority, VGA wins when both request in IDLE.
REQ-023 Defined: both requesting in IDLE -> grant port other than last_owner; single requester always granted; last_owner updated on each grant.

Verification
REQ-024 VGA only, address 0x3F80000, 16 rvalid words 0..15 -> vga_rvalid x16 with matching data, vga_complete x1, cpu_* outputs 0 throughout.
REQ-025 CPU write addr 0x0000100, wdata 0xDEADBEEF, wmask 0xF -> sdram_write=1, burst=0, fields exact; cpu_complete pulses; back to IDLE next cycle.
REQ-026 VGA and CPU request same cycle, twice back-to-back -> without macro VGA,VGA; with macro VGA,CPU (last_owner=CPU after reset).
REQ-027 CPU request raised same cycle as VGA sdram_complete -> CPU grant; sdram_request high 2 cycles after complete.
REQ-028 Reset asserted after 5th rvalid of VGA burst -> state IDLE, remaining 11 rvalid not seen on vga_rvalid, sdram_request 0.
REQ-029 Stray sdram_rvalid=1, rdata 0x12345678 in IDLE -> vga_rvalid=cpu_rvalid=0, state unchanged.
